hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Tracks the 5-bit destination-register tag and write-enable of every in-flight instruction across the EX, MEM and WB stages of the pipelined CPU.
- Detects load-use hazards and stalls the ID stage.
- Generates registered forwarding selects for the instruction entering EX.
- Sits beside the ID/EX/MEM/WB register chain. It is the single controller that decides bubble insertion and operand-bypass source.

Parameters:
- REG_BITS, 5, width of register addresses.
- ZERO_REG, 31, hard-wired zero register: never hazards, never forwarded.
- CNT_BITS, 16, width of the stall performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1  in  REG_BITS  first source register of ID instruction.
- id_rs2  in  REG_BITS  second source register of ID instruction.
- id_use_rs1  in  1  ID instruction reads rs1.
- id_use_rs2  in  1  ID instruction reads rs2.
- id_rd  in  REG_BITS  destination register of ID instruction.
- id_regwrite  in  1  ID instruction writes rd.
- id_memread  in  1  ID instruction is a load.
- flush  in  1  squash ID instruction (taken branch).
- stall  out  1  hold PC and IF/ID; combinational.
- fwd_a  out  2  operand-A bypass select for instruction now in EX: 00 regfile, 01 from MEM result, 10 from WB result.
- fwd_b  out  2  same for operand B.
- ex_rd, mem_rd, wb_rd  out  REG_BITS  destination tag per stage.
- ex_wr, mem_wr, wb_wr  out  1  stage will write its rd (valid & regwrite & rd != ZERO_REG).
- stall_cnt  out  CNT_BITS  saturating count of stall cycles.

Behaviour:
- Reset (reset low, asynchronous):
  - All stage valid/regwrite/memread bits 0; all rd tags 0.
  - fwd_a = fwd_b = 00; stall_cnt = 0.
  - stall = 0 as a consequence. Reset mid-operation discards all tracked instructions immediately.
- Stage entry per stage: {valid, rd, regwrite, memread}. Each rising edge: WB <= MEM, MEM <= EX, always.
- EX load rule:
  - If flush = 1, or stall = 1, or id_valid = 0: EX <= bubble (all bits 0, fwd 00).
  - Otherwise EX <= ID fields, and fwd_a/fwd_b are registered from the rules below.
- Hazard match rule: stage S matches source r when S.valid & S.regwrite & S.rd == r & r != ZERO_REG & use bit set.
- stall (combinational) = id_valid & !flush & EX.memread & (EX matches rs1 or EX matches rs2). Flush overrides stall.
- Forwarding, computed at issue from current stage contents:
  - Current EX match -> 01 (it is in MEM next cycle).
  - Else current MEM match -> 10.
  - Else 00. Younger stage has priority.
- A load in EX never produces 01; that case stalls instead. After one bubble the load is in MEM, so the reissued instruction gets 10.
- A current-WB match needs no forwarding. The register file performs write-before-read in the same cycle.
- id_rd == ZERO_REG with regwrite: tracked, but exposed stage_wr = 0 and never matched.
- Latency:
  - stall responds in the same cycle as the inputs.
  - Tags and fwd selects appear the cycle after issue.
  - A load-use pair costs exactly 1 stall cycle.
- stall_cnt increments by 1 on every edge where stall = 1. It holds at all-ones (no wrap).

Test Plan:
1. Reset-mid-operation: release reset, issue 3 ALU writes to x1, x2, x3, assert reset low -> immediately all *_wr = 0, fwd = 00, stall_cnt = 0.
2. ALU back-to-back: issue ADD x5 then SUB rs1 = x5 next cycle -> SUB in EX shows fwd_a = 01, stall never asserted. Issue with one unrelated instruction between -> fwd_a = 10.
3. Load-use: LDUR x7 then ADD rs2 = x7 -> stall = 1 for exactly 1 cycle, EX holds a bubble, then ADD enters EX with fwd_b = 10, stall_cnt = 1.
4. Priority: x4 written by both EX and MEM instructions, consumer reads x4 -> fwd_a = 01, not 10.
5. Zero register: LDUR x31 then ADD rs1 = x31 -> no stall, fwd_a = 00, ex_wr = 0.
6. Flush during load-use hazard: same as scenario 3 with flush = 1 -> stall = 0, EX bubble, stall_cnt unchanged. Counter saturation: force 2^16 + 3 stall cycles -> stall_cnt = 16'hFFFF.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard scoreboard: tracks destination tags in EX/MEM/WB, stalls ID on
// load-use and registers operand-bypass selects for the instruction entering EX.
module hazard_scoreboard #(
    parameter int unsigned REG_BITS = 5,
    parameter int unsigned ZERO_REG = 31,
    parameter int unsigned CNT_BITS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [REG_BITS-1:0] id_rs1,
    input  logic [REG_BITS-1:0] id_rs2,
    input  logic                id_use_rs1,
    input  logic                id_use_rs2,
    input  logic [REG_BITS-1:0] id_rd,
    input  logic                id_regwrite,
    input  logic                id_memread,
    input  logic                flush,
    output logic                stall,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
    output logic [REG_BITS-1:0] ex_rd,
    output logic [REG_BITS-1:0] mem_rd,
    output logic [REG_BITS-1:0] wb_rd,
    output logic                ex_wr,
    output logic                mem_wr,
    output logic                wb_wr,
    output logic [CNT_BITS-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_MEM = 2'b01,
        FWD_WB  = 2'b10
    } fwd_sel_e;

    localparam logic [REG_BITS-1:0] ZR = REG_BITS'(ZERO_REG);

    // memread only matters while the load sits in EX, so later stages drop it
    logic     ex_valid, ex_regwrite, ex_memread;
    logic     mem_valid, mem_regwrite;
    logic     wb_valid, wb_regwrite;
    fwd_sel_e fwd_a_q, fwd_b_q;
    fwd_sel_e fwd_a_d, fwd_b_d;
    logic     issue;
    logic     ex_m1, ex_m2, mem_m1, mem_m2;

    function automatic logic hit(input logic v, input logic w,
                                 input logic [REG_BITS-1:0] rd,
                                 input logic [REG_BITS-1:0] r,
                                 input logic u);
        return v & w & (rd == r) & (r != ZR) & u;
    endfunction

    always_comb begin
        ex_m1  = hit(ex_valid,  ex_regwrite,  ex_rd,  id_rs1, id_use_rs1);
        ex_m2  = hit(ex_valid,  ex_regwrite,  ex_rd,  id_rs2, id_use_rs2);
        mem_m1 = hit(mem_valid, mem_regwrite, mem_rd, id_rs1, id_use_rs1);
        mem_m2 = hit(mem_valid, mem_regwrite, mem_rd, id_rs2, id_use_rs2);

        stall = id_valid & ~flush & ex_valid & ex_memread & (ex_m1 | ex_m2);
        issue = id_valid & ~flush & ~stall;

        // younger producer wins; a WB producer is covered by regfile write-before-read
        fwd_a_d = FWD_RF;
        if (ex_m1)       fwd_a_d = FWD_MEM;
        else if (mem_m1) fwd_a_d = FWD_WB;

        fwd_b_d = FWD_RF;
        if (ex_m2)       fwd_b_d = FWD_MEM;
        else if (mem_m2) fwd_b_d = FWD_WB;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ex_valid     <= 1'b0;
            ex_regwrite  <= 1'b0;
            ex_memread   <= 1'b0;
            ex_rd        <= '0;
            mem_valid    <= 1'b0;
            mem_regwrite <= 1'b0;
            mem_rd       <= '0;
            wb_valid     <= 1'b0;
            wb_regwrite  <= 1'b0;
            wb_rd        <= '0;
            fwd_a_q      <= FWD_RF;
            fwd_b_q      <= FWD_RF;
            stall_cnt    <= '0;
        end else begin
            wb_valid     <= mem_valid;
            wb_regwrite  <= mem_regwrite;
            wb_rd        <= mem_rd;
            mem_valid    <= ex_valid;
            mem_regwrite <= ex_regwrite;
            mem_rd       <= ex_rd;
            if (issue) begin
                ex_valid    <= 1'b1;
                ex_regwrite <= id_regwrite;
                ex_memread  <= id_memread;
                ex_rd       <= id_rd;
                fwd_a_q     <= fwd_a_d;
                fwd_b_q     <= fwd_b_d;
            end else begin
                ex_valid    <= 1'b0;
                ex_regwrite <= 1'b0;
                ex_memread  <= 1'b0;
                ex_rd       <= '0;
                fwd_a_q     <= FWD_RF;
                fwd_b_q     <= FWD_RF;
            end
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign fwd_a  = fwd_a_q;
    assign fwd_b  = fwd_b_q;
    assign ex_wr  = ex_valid  & ex_regwrite  & (ex_rd  != ZR);
    assign mem_wr = mem_valid & mem_regwrite & (mem_rd != ZR);
    assign wb_wr  = wb_valid  & wb_regwrite  & (wb_rd  != ZR);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard; a second instance with an 8-bit counter
// exercises stall counter saturation in a short run.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid, id_use_rs1, id_use_rs2, id_regwrite, id_memread, flush;
    logic [4:0] id_rs1, id_rs2, id_rd;

    logic        stall, ex_wr, mem_wr, wb_wr;
    logic [1:0]  fwd_a, fwd_b;
    logic [4:0]  ex_rd, mem_rd, wb_rd;
    logic [15:0] stall_cnt;

    logic        s_stall, s_ex_wr, s_mem_wr, s_wb_wr;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [4:0]  s_ex_rd, s_mem_rd, s_wb_rd;
    logic [7:0]  s_stall_cnt;

    int unsigned tests = 0;
    int unsigned fails = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_wr(ex_wr), .mem_wr(mem_wr), .wb_wr(wb_wr), .stall_cnt(stall_cnt)
    );

    hazard_scoreboard #(.CNT_BITS(8)) u_sat (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread), .flush(flush),
        .stall(s_stall), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .ex_rd(s_ex_rd), .mem_rd(s_mem_rd), .wb_rd(s_wb_rd),
        .ex_wr(s_ex_wr), .mem_wr(s_mem_wr), .wb_wr(s_wb_wr), .stall_cnt(s_stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                          input logic [4:0] rs2, input logic u2,
                          input logic [4:0] rd, input logic rw, input logic mr);
        id_valid = v;   id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2;
        id_rd = rd;     id_regwrite = rw; id_memread = mr; flush = 1'b0;
        #1;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        nop();
        #10;
        check("rst_ex_wr",  ex_wr,  1'b0);
        check("rst_mem_wr", mem_wr, 1'b0);
        check("rst_wb_wr",  wb_wr,  1'b0);
        check("rst_fwd",    {fwd_a, fwd_b}, 4'b0000);
        check("rst_cnt",    stall_cnt, 16'd0);
        check("rst_stall",  stall, 1'b0);
        reset = 1'b1;
        step();

        // three ALU writes, then reset mid-flight
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0); step();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0); step();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0); step();
        check("fill_tags", {ex_rd, mem_rd, wb_rd}, {5'd3, 5'd2, 5'd1});
        check("fill_wr",   {ex_wr, mem_wr, wb_wr}, 3'b111);
        nop();
        #2 reset = 1'b0;
        #1;
        check("mid_rst_wr",  {ex_wr, mem_wr, wb_wr}, 3'b000);
        check("mid_rst_tag", {ex_rd, mem_rd, wb_rd}, 15'd0);
        check("mid_rst_fwd", {fwd_a, fwd_b}, 4'b0000);
        check("mid_rst_cnt", stall_cnt, 16'd0);
        reset = 1'b1;
        step();

        // back-to-back ALU dependency
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0); step();
        set_id(1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 5'd8, 1'b1, 1'b0);
        check("b2b_stall", stall, 1'b0);
        step();
        check("b2b_fwd", {fwd_a, fwd_b}, 4'b0100);
        check("b2b_exrd", ex_rd, 5'd8);

        // one instruction between producer and consumer; rs2 hits the adjacent one
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9,  1'b1, 1'b0); step();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0); step();
        set_id(1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 5'd11, 1'b1, 1'b0);
        check("gap_stall", stall, 1'b0);
        step();
        check("gap_fwd", {fwd_a, fwd_b}, 4'b1001);
        // now x9 is in WB and x10 in MEM
        set_id(1'b1, 5'd9, 1'b1, 5'd10, 1'b1, 5'd12, 1'b1, 1'b0); step();
        check("wb_nofwd", {fwd_a, fwd_b}, 4'b0010);

        // load-use costs one bubble, then bypass from WB
        nop(); step(); step(); step();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1); step();
        set_id(1'b1, 5'd2, 1'b1, 5'd7, 1'b1, 5'd12, 1'b1, 1'b0);
        check("lu_stall", stall, 1'b1);
        step();
        check("lu_bubble_wr", ex_wr, 1'b0);
        check("lu_bubble_rd", ex_rd, 5'd0);
        check("lu_bubble_fwd", {fwd_a, fwd_b}, 4'b0000);
        check("lu_stall_clr", stall, 1'b0);
        step();
        check("lu_issue", {ex_wr, ex_rd}, {1'b1, 5'd12});
        check("lu_fwd", {fwd_a, fwd_b}, 4'b0010);
        check("lu_mem_bubble", mem_wr, 1'b0);
        check("lu_cnt", stall_cnt, 16'd1);

        // both EX and MEM write x4: younger wins
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0); step();
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0); step();
        set_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0); step();
        check("prio_fwd", {fwd_a, fwd_b}, 4'b0100);

        // zero register load never hazards
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd31, 1'b1, 1'b1); step();
        check("zr_ex_wr", {ex_wr, ex_rd}, {1'b0, 5'd31});
        set_id(1'b1, 5'd31, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0);
        check("zr_stall", stall, 1'b0);
        step();
        check("zr_fwd", {fwd_a, fwd_b}, 4'b0000);

        // flush overrides a load-use stall
        set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1); step();
        set_id(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd15, 1'b1, 1'b0);
        flush = 1'b1;
        #1;
        check("fl_stall", stall, 1'b0);
        step();
        check("fl_bubble", {ex_wr, ex_rd}, 6'd0);
        check("fl_cnt", stall_cnt, 16'd1);

        // self-dependent load held in ID stalls every other cycle
        set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
        repeat (506) step();
        check("sat_pre", s_stall_cnt, 8'hFE);
        check("cnt_pre", stall_cnt, 16'd254);
        repeat (94) step();
        check("sat_hold", s_stall_cnt, 8'hFF);
        check("cnt_post", stall_cnt, 16'd301);

        nop();
        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
